// File: rtl/fetch_seq_pkg.sv
// Shared constants for the fetch sequencer, its return-address stack and the CU.
package fetch_seq_pkg;

  localparam int ADDR_W    = 5;
  localparam int INSTR_W   = 15;
  localparam int STK_DEPTH = 4;

  localparam logic [ADDR_W-1:0] RST_PC = '0;

  // Program space is a power of two, so the increment wraps 31->0 on its own.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_seq_ret_stack.sv
// Return-address LIFO: push/pop/top/full/empty, pop wins over a simultaneous push.
// Single-cycle update; pushes when full and pops when empty are ignored here.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_val,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SP_W  = $clog2(DEPTH + 1);

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp;

  assign empty = (sp == '0);
  assign full  = (sp == SP_W'(DEPTH));
  assign top   = empty ? '0 : mem[IDX_W'(sp - SP_W'(1))];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (pop) begin
      if (!empty) begin
        sp <= sp - SP_W'(1);
      end
    end else if (push && !full) begin
      mem[IDX_W'(sp)] <= push_val;
      sp              <= sp + SP_W'(1);
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the pc, registers program memory data into a valid/ready output.
// First instruction 2 edges after reset or redirect; a 1-entry skid absorbs the in-flight word on stall.
module fetch_seq
  import fetch_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  pm_addr,
  input  logic [INSTR_W-1:0] pm_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               br_call,
  input  logic               br_ret,
  output logic               stk_err
);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  f_pc;
  logic               f_vld;
  logic [ADDR_W-1:0]  skid_pc;
  logic [INSTR_W-1:0] skid_dat;
  logic               skid_full;

  logic               accept;
  logic               out_free;
  logic               redirect;
  logic               issue;

  logic [ADDR_W-1:0]  tgt;
  logic               err_set;
  logic               stk_push;
  logic               stk_pop;
  logic [ADDR_W-1:0]  stk_top;
  logic               stk_full;
  logic               stk_empty;

  assign pm_addr  = pc;
  assign accept   = instr_valid && instr_ready;
  assign out_free = !instr_valid || instr_ready;
  assign redirect = accept && br_taken;
  assign issue    = !skid_full && !(instr_valid && !instr_ready) && !redirect;

  // Return beats call when both are raised; overflow still takes the jump.
  always_comb begin
    tgt      = br_target;
    err_set  = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    if (redirect) begin
      if (br_ret) begin
        stk_pop = !stk_empty;
        err_set = stk_empty;
        tgt     = stk_empty ? '0 : stk_top;
      end else if (br_call) begin
        stk_push = !stk_full;
        err_set  = stk_full;
      end
    end
  end

  ret_stack #(
    .DEPTH (STK_DEPTH),
    .W     (ADDR_W)
  ) u_ret_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_val (next_pc(instr_pc)),
    .top      (stk_top),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RST_PC;
      f_pc        <= '0;
      f_vld       <= 1'b0;
      skid_pc     <= '0;
      skid_dat    <= '0;
      skid_full   <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      stk_err     <= 1'b0;
    end else begin
      if (err_set) begin
        stk_err <= 1'b1;
      end

      if (redirect) begin
        // Wrong-path words in flight or parked in the skid are dropped here.
        pc          <= tgt;
        f_vld       <= 1'b0;
        skid_full   <= 1'b0;
        instr_valid <= 1'b0;
      end else begin
        f_vld <= issue;
        if (issue) begin
          pc   <= next_pc(pc);
          f_pc <= pc;
        end

        if (out_free) begin
          if (skid_full) begin
            instr       <= skid_dat;
            instr_pc    <= skid_pc;
            instr_valid <= 1'b1;
            if (f_vld) begin
              skid_dat <= pm_data;
              skid_pc  <= f_pc;
            end else begin
              skid_full <= 1'b0;
            end
          end else if (f_vld) begin
            instr       <= pm_data;
            instr_pc    <= f_pc;
            instr_valid <= 1'b1;
          end else begin
            instr_valid <= 1'b0;
          end
        end else if (f_vld) begin
          skid_dat  <= pm_data;
          skid_pc   <= f_pc;
          skid_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: instruction-stream reference model plus directed and random stimulus.
module tb_fetch_seq;
  import fetch_seq_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [ADDR_W-1:0]  pm_addr;
  logic [INSTR_W-1:0] pm_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready = 1'b0;
  logic               br_taken = 1'b0;
  logic [ADDR_W-1:0]  br_target = '0;
  logic               br_call = 1'b0;
  logic               br_ret = 1'b0;
  logic               stk_err;

  logic [INSTR_W-1:0] mem [32];
  int checks = 0;
  int errors = 0;

  fetch_seq dut (
    .clk         (clk),
    .rst         (rst),
    .pm_addr     (pm_addr),
    .pm_data     (pm_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .br_call     (br_call),
    .br_ret      (br_ret),
    .stk_err     (stk_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read program memory.
  always @(posedge clk) pm_data <= mem[pm_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the expected instruction", name);
  endtask

  // Reference model: the sequence of instructions the CU must see.
  int exp_pc = 0;
  int stk[$];
  bit exp_err = 0;
  int since = 0;
  int gap = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 0;
      stk.delete();
      exp_err = 0;
      since = 0;
      gap = 0;
    end else begin
      chk("stk_err", stk_err, exp_err);
      if (since == 1 || since == 2) begin
        chk("redirect_bubble", instr_valid, 0);
        since++;
      end else if (since == 3) begin
        chk("redirect_resume", instr_valid, 1);
        since = 0;
      end
      if (instr_valid === 1'b1) begin
        gap = 0;
        chk("instr_pc", instr_pc, exp_pc);
        chk("instr_data", instr, mem[exp_pc]);
        if (instr_ready) begin
          if (br_taken) begin
            since = 1;
            if (br_ret) begin
              if (stk.size() == 0) begin
                exp_err = 1;
                exp_pc = 0;
              end else begin
                exp_pc = stk.pop_back();
              end
            end else begin
              if (br_call) begin
                if (stk.size() == STK_DEPTH) exp_err = 1;
                else stk.push_back((exp_pc + 1) % 32);
              end
              exp_pc = int'(br_target);
            end
          end else begin
            exp_pc = (exp_pc + 1) % 32;
          end
        end
      end else begin
        gap++;
        if (gap > 6) begin
          fail_to("valid_gap");
          gap = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_br();
    br_taken = 1'b0;
    br_call  = 1'b0;
    br_ret   = 1'b0;
  endtask

  task automatic wait_pc(input int pc, input string name);
    int n;
    n = 0;
    while (!(instr_valid === 1'b1 && int'(instr_pc) == pc) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) fail_to(name);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) fail_to(name);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pm_addr"}, pm_addr, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_instr_pc"}, instr_pc, 0);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_stk_err"}, stk_err, 0);
  endtask

  // Called with rst just released between edges.
  task automatic startup(input string tag);
    tick();
    chk({tag, "_edge1_valid"}, instr_valid, 0);
    chk({tag, "_edge1_pm_addr"}, pm_addr, 1);
    tick();
    chk({tag, "_edge2_valid"}, instr_valid, 1);
    chk({tag, "_edge2_pc"}, instr_pc, 0);
    chk({tag, "_edge2_data"}, instr, mem[0]);
    chk({tag, "_edge2_err"}, stk_err, 0);
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk_zero(tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
    instr_ready = 1'b1;
    clear_br();
    startup(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cpc [5] = '{10, 8, 12, 16, 20};
    int ctg [5] = '{8, 12, 16, 20, 24};
    int rpc [5] = '{24, 17, 13, 9, 11};
    int rex [5] = '{17, 13, 9, 11, 0};

    for (int i = 0; i < 32; i++) mem[i] = INSTR_W'($urandom);

    // Power-up reset and start-up latency.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk_zero("reset");
    rst = 1'b0;
    instr_ready = 1'b1;
    startup("boot");

    // Full-rate stream across the 31->0 wrap.
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("stream_valid", instr_valid, 1);
      chk("stream_pc", instr_pc, k % 32);
    end

    // Three-cycle stall holding address 5; fetch stalls at pc 7.
    wait_pc(5, "stall_wait");
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pc", instr_pc, 5);
      chk("stall_pm_addr", pm_addr, 7);
    end
    instr_ready = 1'b1;
    tick();
    chk("release_pc", instr_pc, 6);
    tick();
    wait_valid("release_next");
    chk("release_next_pc", instr_pc, 7);

    // Jump at 4 to 12.
    wait_pc(4, "jump_wait");
    br_taken = 1'b1;
    br_target = 5'd12;
    tick();
    clear_br();
    chk("jump_gap1", instr_valid, 0);
    tick();
    chk("jump_gap2", instr_valid, 0);
    tick();
    chk("jump_valid", instr_valid, 1);
    chk("jump_pc", instr_pc, 12);

    // Call at 3 to 20, return at 22.
    wait_pc(3, "call_wait");
    br_taken = 1'b1;
    br_call = 1'b1;
    br_target = 5'd20;
    tick();
    clear_br();
    wait_pc(22, "ret_wait");
    br_taken = 1'b1;
    br_ret = 1'b1;
    br_target = 5'd30;
    tick();
    clear_br();
    wait_valid("ret_land");
    chk("ret_pc", instr_pc, 4);
    chk("ret_err", stk_err, 0);

    // Five nested calls overflow a four-deep stack, then five returns.
    for (int k = 0; k < 5; k++) begin
      wait_pc(cpc[k], "nest_call_wait");
      br_taken = 1'b1;
      br_call = 1'b1;
      br_target = ADDR_W'(ctg[k]);
      tick();
      clear_br();
      chk("nest_err", stk_err, (k == 4) ? 1 : 0);
    end
    for (int k = 0; k < 5; k++) begin
      wait_pc(rpc[k], "nest_ret_wait");
      br_taken = 1'b1;
      br_ret = 1'b1;
      br_target = 5'd30;
      tick();
      clear_br();
      wait_valid("nest_ret_land");
      chk("nest_ret_pc", instr_pc, rex[k]);
    end
    chk("underflow_err", stk_err, 1);

    // Reset in the middle of a stall with the skid occupied.
    instr_ready = 1'b0;
    tick();
    tick();
    pulse_reset("midrst");

    // Random traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) pulse_reset("rndrst");
      instr_ready = ($urandom_range(0, 3) != 0);
      br_taken    = ($urandom_range(0, 5) == 0);
      br_call     = $urandom_range(0, 1) == 1;
      br_ret      = ($urandom_range(0, 3) == 0);
      br_target   = ADDR_W'($urandom_range(0, 31));
      tick();
    end
    clear_br();
    instr_ready = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
